branch_target_pipe: RTL

Parametrised, two-stage pipelined branch/jump target generator for the EX stage. It generalises the single-mode combinational PC+offset adder with four addressing modes, a valid/ready handshake, back-pressure, flush, and alignment/overflow flags. Requests carry a tag so the consumer (PC-select / hazard logic) can match each result to its originating instruction.

---
 rtl/branch_target_pipe_pkg.sv | 24 ++
 rtl/branch_target_pipe_if.sv | 31 +++
 rtl/branch_target_pipe_pipe_reg_stage.sv | 37 +++
 rtl/branch_target_pipe.sv | 109 ++++++++++
 4 files changed

// File: rtl/branch_target_pipe_pkg.sv
// Shared branch-target definitions: addressing-mode encodings and default datapath
// constants used by PC-select, decode and the EX-stage target generator.
package branch_target_pipe_pkg;

  localparam int BT_WIDTH       = 32;
  localparam int BT_SHIFT       = 2;
  localparam int BT_INC         = 4;
  localparam int BT_REGION_BITS = 4;
  localparam int BT_TAG_W       = 5;

  typedef enum logic [1:0] {
    BT_PC_REL     = 2'd0,
    BT_NPC_REL    = 2'd1,
    BT_ABS_REGION = 2'd2,
    BT_REG_IND    = 2'd3
  } bt_mode_e;

  // Two's-complement overflow from the operand and result sign bits.
  function automatic logic add_ovf(input logic base_msb, input logic off_msb,
                                   input logic sum_msb);
    return (base_msb == off_msb) && (sum_msb != base_msb);
  endfunction

endpackage

// File: rtl/branch_target_pipe_if.sv
// Request/response bus of the branch target generator; the producer side is the
// master, the target generator itself is the slave.
interface branch_target_pipe_if #(
  parameter int WIDTH = branch_target_pipe_pkg::BT_WIDTH,
  parameter int TAG_W = branch_target_pipe_pkg::BT_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_rs;
  logic [WIDTH-1:0] in_imm;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_target;
  logic [TAG_W-1:0] out_tag;
  logic             out_misaligned;
  logic             out_overflow;

  modport master (
    output in_valid, in_mode, in_pc, in_rs, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_target, out_tag, out_misaligned, out_overflow
  );

  modport slave (
    input  in_valid, in_mode, in_pc, in_rs, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_target, out_tag, out_misaligned, out_overflow
  );
endinterface

// File: rtl/branch_target_pipe_pipe_reg_stage.sv
// One valid/ready register slice: full-throughput, holds its contents under
// back-pressure, and drops its valid bit on a synchronous flush.
module pipe_reg_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so chained slices shift by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset too because it drives visible outputs that
      // must read zero during reset; it is a small register, not a memory.
      out_data  <= '0;
    end else begin
      if (flush)    out_valid <= 1'b0;
      else if (adv) out_valid <= in_valid;

      if (adv && in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/branch_target_pipe.sv
// Two-stage EX-stage branch/jump target generator: stage 1 selects base/offset
// per addressing mode, stage 2 adds them and flags misalignment and overflow.
module branch_target_pipe
  import branch_target_pipe_pkg::*;
#(
  parameter int WIDTH       = BT_WIDTH,
  parameter int SHIFT       = BT_SHIFT,
  parameter int INC         = BT_INC,
  parameter int REGION_BITS = BT_REGION_BITS,  // must stay below WIDTH-SHIFT
  parameter int TAG_W       = BT_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  branch_target_pipe_if.slave bus
);

  typedef struct packed {
    bt_mode_e         mode;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] offset;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] target;
    logic [TAG_W-1:0] tag;
    logic             misaligned;
    logic             overflow;
  } s2_t;

  localparam logic [WIDTH-1:0] REGION_MASK = ~({WIDTH{1'b1}} >> REGION_BITS);
  localparam logic [WIDTH-1:0] ALIGN_MASK  = ~({WIDTH{1'b1}} << SHIFT);

  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             s1_valid, s2_ready;
  logic [WIDTH-1:0] npc, imm_sh, sum;

  assign npc    = bus.in_pc + WIDTH'(INC);
  assign imm_sh = bus.in_imm << SHIFT;

  // NOTE: assigning a default first makes every path drive s1_d, so no latch.
  always_comb begin
    s1_d      = '0;
    s1_d.mode = bt_mode_e'(bus.in_mode);
    s1_d.tag  = bus.in_tag;
    case (bus.in_mode)
      BT_PC_REL: begin
        s1_d.base   = bus.in_pc;
        s1_d.offset = imm_sh;
      end
      BT_NPC_REL: begin
        s1_d.base   = npc;
        s1_d.offset = imm_sh;
      end
      BT_ABS_REGION: begin
        // Upper region bits from the next PC, the rest from the shifted immediate.
        s1_d.base   = (npc & REGION_MASK) | (imm_sh & ~REGION_MASK);
        s1_d.offset = '0;
      end
      default: begin
        s1_d.base   = bus.in_rs;
        s1_d.offset = bus.in_imm;
      end
    endcase
  end

  pipe_reg_stage #(.DW($bits(s1_t))) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (s1_d),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_q)
  );

  assign sum = s1_q.base + s1_q.offset;

  always_comb begin
    s2_d            = '0;
    s2_d.target     = sum;
    s2_d.tag        = s1_q.tag;
    s2_d.misaligned = |(sum & ALIGN_MASK);
    s2_d.overflow   = (s1_q.mode != BT_ABS_REGION) &&
                      add_ovf(s1_q.base[WIDTH-1], s1_q.offset[WIDTH-1], sum[WIDTH-1]);
  end

  pipe_reg_stage #(.DW($bits(s2_t))) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_d),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (s2_q)
  );

  assign bus.out_target     = s2_q.target;
  assign bus.out_tag        = s2_q.tag;
  assign bus.out_misaligned = s2_q.misaligned;
  assign bus.out_overflow   = s2_q.overflow;

endmodule
